shmem_responder: RTL and testbench



---
 rtl/gpu_pkg.sv | 23 ++
 rtl/shmem_rr_arbiter.sv | 31 +++
 rtl/shmem_responder.sv | 125 ++++++++++++
 tb/tb_shmem_responder.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the core-to-shared-memory responder slice.
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } shmem_state_t;

    localparam int SHMEM_ADDR_W = 12;
    localparam int SHMEM_DATA_W = 8;

    typedef enum logic {
        OP_LD = 1'b0,
        OP_ST = 1'b1
    } shmem_op_t;

    // Index width that stays legal (>= 1 bit) when only one entry exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shmem_rr_arbiter.sv
// Combinational round-robin pick: first pending index at or after rr_ptr,
// wrapping modulo N_CORES. The pointer itself lives in the responder.
module shmem_rr_arbiter
    import gpu_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int PTR_W   = idx_w(N_CORES)
) (
    input  logic [N_CORES-1:0] pending,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   gnt,
    output logic               any_valid
);

    // NOTE: every output gets a default before the loop, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        logic [PTR_W-1:0] idx;
        gnt       = '0;
        any_valid = 1'b0;
        // Walk from the farthest offset down so the nearest hit wins.
        for (int k = N_CORES - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(rr_ptr) + k) % N_CORES);
            if (pending[idx]) begin
                gnt       = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shmem_responder.sv
// Shared-memory responder: round-robin among cores, one byte access per
// IDLE->ACCESS->RESP pass. Optional counters under SHMEM_STATS_EN.
module shmem_responder
    import gpu_pkg::*;
#(
    parameter int N_CORES   = 4,
    parameter int ADDR_W    = SHMEM_ADDR_W,
    parameter int DATA_W    = SHMEM_DATA_W,
    parameter int MEM_DEPTH = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CORES-1:0]         req_ld,
    input  logic [N_CORES-1:0]         req_st,
    input  logic [N_CORES*ADDR_W-1:0]  addr,
    input  logic [N_CORES*DATA_W-1:0]  dat_st,
    output logic [DATA_W-1:0]          mem_dat,
    output logic [N_CORES-1:0]         val_data,
    output logic                       busy,
    output logic                       err_both
`ifdef SHMEM_STATS_EN
    ,
    output logic [15:0]                ld_cnt,
    output logic [15:0]                st_cnt
`endif
);

    localparam int PTR_W  = idx_w(N_CORES);
    localparam int MEM_AW = idx_w(MEM_DEPTH);

    shmem_state_t      state;
    shmem_state_t      state_next;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  gnt;
    logic [PTR_W-1:0]  gnt_q;
    logic              any_valid;
    shmem_op_t         op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              in_range;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    shmem_rr_arbiter #(
        .N_CORES (N_CORES),
        .PTR_W   (PTR_W)
    ) u_arb (
        .pending   (req_ld | req_st),
        .rr_ptr    (rr_ptr),
        .gnt       (gnt),
        .any_valid (any_valid)
    );

    // Extra top bit keeps the compare exact when MEM_DEPTH == 2**ADDR_W.
    assign in_range = {1'b0, addr_q} < (ADDR_W + 1)'(MEM_DEPTH);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_valid) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_q    <= '0;
            op_q     <= OP_LD;
            addr_q   <= '0;
            data_q   <= '0;
            mem_dat  <= '0;
            err_both <= 1'b0;
        end else begin
            state <= state_next;
            if (|(req_ld & req_st)) err_both <= 1'b1;
            case (state)
                IDLE: if (any_valid) begin
                    gnt_q  <= gnt;
                    op_q   <= req_ld[gnt] ? OP_LD : OP_ST;
                    addr_q <= addr[gnt*ADDR_W +: ADDR_W];
                    data_q <= dat_st[gnt*DATA_W +: DATA_W];
                end
                ACCESS: if (op_q == OP_LD) begin
                    mem_dat <= in_range ? mem[addr_q[MEM_AW-1:0]] : '0;
                end
                RESP: rr_ptr <= (int'(gnt_q) == N_CORES - 1) ? '0 : gnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the array has no reset; contents survive reset, only the
    // control path is cleared. Reset still blocks an in-flight store.
    always_ff @(posedge clk) begin
        if (!reset && state == ACCESS && op_q == OP_ST && in_range) begin
            mem[addr_q[MEM_AW-1:0]] <= data_q;
        end
    end

    always_comb begin
        val_data = '0;
        if (state == RESP && !reset) val_data[gnt_q] = 1'b1;
    end

    assign busy = (state != IDLE);

`ifdef SHMEM_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt <= '0;
            st_cnt <= '0;
        end else if (state == RESP) begin
            if (op_q == OP_LD && ld_cnt != 16'hFFFF) ld_cnt <= ld_cnt + 16'd1;
            if (op_q == OP_ST && st_cnt != 16'hFFFF) st_cnt <= st_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shmem_responder.sv
// Self-checking bench for shmem_responder: directed vector table, multi-cycle
// sequences and randomized traffic against a cycle-timeline reference model.
module tb_shmem_responder;

    localparam int N     = 4;
    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_ld;
    logic [N-1:0]    req_st;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] dat_st;
    logic [DW-1:0]   mem_dat;
    logic [N-1:0]    val_data;
    logic            busy;
    logic            err_both;
`ifdef SHMEM_STATS_EN
    logic [15:0]     ld_cnt;
    logic [15:0]     st_cnt;
`endif

    shmem_responder #(
        .N_CORES   (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_ld   (req_ld),
        .req_st   (req_st),
        .addr     (addr),
        .dat_st   (dat_st),
        .mem_dat  (mem_dat),
        .val_data (val_data),
        .busy     (busy),
        .err_both (err_both)
`ifdef SHMEM_STATS_EN
        ,
        .ld_cnt   (ld_cnt),
        .st_cnt   (st_cnt)
`endif
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    bit  chk_en   = 1'b0;
    bit  rand_en  = 1'b0;
    bit  rst_req  = 1'b1;

    // Core-side request state
    bit            c_act   [N];
    bit            c_ld    [N];
    bit            c_st    [N];
    logic [AW-1:0] c_addr  [N];
    logic [DW-1:0] c_dat   [N];
    int            c_start [N];

    // Completion log as observed on the DUT pins
    int            log_core[$];
    int            log_cyc [$];
    logic [DW-1:0] log_dat [$];

    // Reference model: timeline of the current access plus a byte array
    int            m_left = 0;
    int            m_gnt  = 0;
    int            m_rr   = 0;
    bit            m_ld   = 1'b0;
    int            m_addr = 0;
    logic [7:0]    m_wdat = '0;
    logic [7:0]    m_dat  = '0;
    bit            m_dat_known = 1'b1;
    bit            m_err  = 1'b0;
    logic [7:0]    mem_m  [DEPTH];
    bit            known  [DEPTH];

    typedef struct {
        int         core;
        bit         ld;
        bit         st;
        int         a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input int i, input bit ld, input bit st, input int a, input logic [7:0] d);
        c_act[i]   = 1'b1;
        c_ld[i]    = ld;
        c_st[i]    = st;
        c_addr[i]  = AW'(a);
        c_dat[i]   = d;
        c_start[i] = cyc;
    endtask

    task automatic issue_rand(input int i);
        bit ld;
        bit st;
        int a;
        ld = ($urandom_range(1) == 1);
        st = !ld;
        if ($urandom_range(15) == 0) begin
            ld = 1'b1;
            st = 1'b1;
        end
        a = ($urandom_range(4) == 0) ? int'($urandom_range(511, 256)) : int'($urandom_range(63));
        issue(i, ld, st, a, 8'($urandom_range(255)));
    endtask

    // Advance the model by one clock edge using the inputs driven this cycle.
    task automatic model_advance(input logic [N-1:0] dl, input logic [N-1:0] ds);
        if (rst_req) begin
            m_left      = 0;
            m_rr        = 0;
            m_dat       = '0;
            m_dat_known = 1'b1;
            m_err       = 1'b0;
            return;
        end
        if ((dl & ds) != '0) m_err = 1'b1;
        if (m_left == 0) begin
            if ((dl | ds) != '0) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_rr + k) % N;
                    if (dl[j] || ds[j]) begin
                        m_gnt = j;
                        break;
                    end
                end
                m_ld   = dl[m_gnt];
                m_addr = int'(c_addr[m_gnt]);
                m_wdat = c_dat[m_gnt];
                m_left = 2;
            end
        end else if (m_left == 2) begin
            if (m_addr < DEPTH) begin
                if (m_ld) begin
                    m_dat       = mem_m[m_addr];
                    m_dat_known = known[m_addr];
                end else begin
                    mem_m[m_addr] = m_wdat;
                    known[m_addr] = 1'b1;
                end
            end else if (m_ld) begin
                m_dat       = '0;
                m_dat_known = 1'b1;
            end
            m_left = 1;
        end else begin
            m_rr   = (m_gnt + 1) % N;
            m_left = 0;
        end
    endtask

    // One clock: sample at negedge, retire/issue requests, drive, advance model.
    task automatic step();
        logic [N-1:0] exp_val;
        logic [N-1:0] dl;
        logic [N-1:0] ds;
        @(negedge clk);
        if (chk_en) begin
            exp_val = (m_left == 1) ? (N'(1) << m_gnt) : '0;
            check("busy", 32'(busy), 32'(m_left != 0));
            check("val_data", 32'(val_data), 32'(exp_val));
            check("err_both", 32'(err_both), 32'(m_err));
            if (m_dat_known) check("mem_dat", 32'(mem_dat), 32'(m_dat));
        end
        for (int i = 0; i < N; i++) begin
            if (chk_en && val_data[i] === 1'b1) begin
                check("val_for_active_core", 32'(c_act[i]), 32'd1);
                if (c_act[i]) begin
                    log_core.push_back(i);
                    log_cyc.push_back(cyc);
                    log_dat.push_back(mem_dat);
                    if (rand_en) check("wait_bound", 32'((cyc - c_start[i]) <= 3 * N + 2), 32'd1);
                    c_act[i] = 1'b0;
                end
            end
        end
        if (rand_en) begin
            for (int i = 0; i < N; i++) begin
                if (!c_act[i] && $urandom_range(3) == 0) issue_rand(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            dl[i] = c_act[i] & c_ld[i];
            ds[i] = c_act[i] & c_st[i];
            addr[i*AW +: AW]   = c_addr[i];
            dat_st[i*DW +: DW] = c_dat[i];
        end
        req_ld = dl;
        req_st = ds;
        reset  = rst_req;
        model_advance(dl, ds);
        cyc++;
    endtask

    function automatic bit any_active();
        bit r;
        r = 1'b0;
        for (int i = 0; i < N; i++) r |= c_act[i];
        return r;
    endfunction

    task automatic wait_served(input int i, input int budget);
        int n;
        n = 0;
        while (c_act[i] && n < budget) begin
            step();
            n++;
        end
        check("request_served", 32'(c_act[i]), 32'd0);
    endtask

    task automatic wait_all(input int budget);
        int n;
        n = 0;
        while (any_active() && n < budget) begin
            step();
            n++;
        end
        check("all_served", 32'(any_active()), 32'd0);
    endtask

    task automatic pulse_reset();
        rst_req = 1'b1;
        for (int i = 0; i < N; i++) c_act[i] = 1'b0;
        step();
        rst_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset  = 1'b1;
        req_ld = '0;
        req_st = '0;
        addr   = '0;
        dat_st = '0;
        for (int i = 0; i < N; i++) begin
            c_act[i]  = 1'b0;
            c_ld[i]   = 1'b0;
            c_st[i]   = 1'b0;
            c_addr[i] = '0;
            c_dat[i]  = '0;
            c_start[i] = 0;
        end
        for (int a = 0; a < DEPTH; a++) begin
            mem_m[a] = '0;
            known[a] = 1'b0;
        end

        vecs[0]  = '{0, 1'b0, 1'b1, 'h005, 8'hA5, 8'h00};
        vecs[1]  = '{0, 1'b1, 1'b0, 'h005, 8'h00, 8'hA5};
        vecs[2]  = '{0, 1'b0, 1'b1, 'h040, 8'h11, 8'h00};
        vecs[3]  = '{1, 1'b0, 1'b1, 'h041, 8'h22, 8'h00};
        vecs[4]  = '{2, 1'b0, 1'b1, 'h042, 8'h33, 8'h00};
        vecs[5]  = '{3, 1'b0, 1'b1, 'h043, 8'h44, 8'h00};
        vecs[6]  = '{1, 1'b0, 1'b1, 'h010, 8'hC3, 8'h00};
        vecs[7]  = '{2, 1'b0, 1'b1, 'h020, 8'h6E, 8'h00};
        vecs[8]  = '{3, 1'b0, 1'b1, 'h0FF, 8'h99, 8'h00};
        vecs[9]  = '{0, 1'b1, 1'b0, 'h1FF, 8'h00, 8'h00};
        vecs[10] = '{1, 1'b0, 1'b1, 'h1FF, 8'h77, 8'h00};
        vecs[11] = '{2, 1'b1, 1'b0, 'h0FF, 8'h00, 8'h99};
        vecs[12] = '{3, 1'b1, 1'b0, 'h010, 8'h00, 8'hC3};

        repeat (3) step();
        rst_req = 1'b0;
        chk_en  = 1'b1;
        step();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_val_data", 32'(val_data), 32'd0);
        check("reset_mem_dat", 32'(mem_dat), 32'd0);
        check("reset_err_both", 32'(err_both), 32'd0);

        // Single-core vectors: latency, served core and load data
        foreach (vecs[v]) begin
            n0 = log_core.size();
            issue(vecs[v].core, vecs[v].ld, vecs[v].st, vecs[v].a, vecs[v].d);
            wait_served(vecs[v].core, 12);
            check("vec_logged", 32'(log_core.size()), 32'(n0 + 1));
            if (log_core.size() == n0 + 1) begin
                check("vec_core", 32'(log_core[n0]), 32'(vecs[v].core));
                check("vec_latency", 32'(log_cyc[n0] - c_start[vecs[v].core]), 32'd2);
                if (vecs[v].ld) check("vec_data", 32'(log_dat[n0]), 32'(vecs[v].exp));
            end
        end

        // Four simultaneous loads: served 0,1,2,3, three cycles apart
        n0 = log_core.size();
        for (int i = 0; i < N; i++) issue(i, 1'b1, 1'b0, 'h040 + i, 8'h00);
        wait_all(30);
        check("burst_count", 32'(log_core.size()), 32'(n0 + 4));
        if (log_core.size() == n0 + 4) begin
            for (int k = 0; k < 4; k++) begin
                check("burst_order", 32'(log_core[n0+k]), 32'(k));
                check("burst_data", 32'(log_dat[n0+k]), 32'(8'h11 * (k + 1)));
                if (k > 0) check("burst_spacing", 32'(log_cyc[n0+k] - log_cyc[n0+k-1]), 32'd3);
            end
        end

        // After core2 is served, cores 0 and 3 together: 3 goes first
        issue(2, 1'b1, 1'b0, 'h042, 8'h00);
        wait_served(2, 12);
        n0 = log_core.size();
        issue(0, 1'b1, 1'b0, 'h040, 8'h00);
        issue(3, 1'b1, 1'b0, 'h043, 8'h00);
        wait_all(20);
        check("rr_count", 32'(log_core.size()), 32'(n0 + 2));
        if (log_core.size() == n0 + 2) begin
            check("rr_first", 32'(log_core[n0]), 32'd3);
            check("rr_second", 32'(log_core[n0+1]), 32'd0);
        end

        // Reset during the ACCESS cycle of a store of 0x5A to 0x010
        issue(1, 1'b0, 1'b1, 'h010, 8'h5A);
        step();
        pulse_reset();
        n0 = log_core.size();
        repeat (4) step();
        check("no_pulse_after_reset", 32'(log_core.size()), 32'(n0));
        check("busy_after_reset", 32'(busy), 32'd0);
        issue(1, 1'b1, 1'b0, 'h010, 8'h00);
        wait_served(1, 12);
        check("aborted_store_not_written", 32'(log_dat[$]), 32'h0C3);
        check("fresh_latency", 32'(log_cyc[$] - c_start[1]), 32'd2);

        // Load and store together from one core: load wins, err_both sticks
        issue(1, 1'b1, 1'b1, 'h020, 8'hEE);
        wait_served(1, 12);
        check("both_load_data", 32'(log_dat[$]), 32'h06E);
        check("err_both_set", 32'(err_both), 32'd1);
        issue(0, 1'b0, 1'b1, 'h021, 8'h12);
        wait_served(0, 12);
        issue(2, 1'b1, 1'b0, 'h021, 8'h00);
        wait_served(2, 12);
        check("normal_after_err", 32'(log_dat[$]), 32'h012);
        check("err_both_sticky", 32'(err_both), 32'd1);
        issue(3, 1'b1, 1'b0, 'h020, 8'h00);
        wait_served(3, 12);
        check("ignored_store", 32'(log_dat[$]), 32'h06E);

        // Randomized traffic against the model
        rand_en = 1'b1;
        repeat (400) step();
        rand_en = 1'b0;
        wait_all(60);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
